// File: rtl/filter_pkg.sv
// Shared constants, rule/header types and the SOP header parser for the multi-rule RX filter.
package filter_pkg;

    localparam int MAX_RULES = 16;
    localparam int WIN_W     = $clog2(MAX_RULES);

    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;

    localparam int OFF_ETYPE      = 12;
    localparam int OFF_IPV4_DST   = 30;
    localparam int OFF_IPV4_DPORT = 36;
    localparam int OFF_IPV6_DST   = 38;
    localparam int OFF_IPV6_DPORT = 56;

    typedef struct packed {
        logic         en;
        logic [31:0]  ipv4;
        logic [127:0] ipv6;
        logic [15:0]  port;
    } rule_t;

    typedef struct packed {
        logic         is_ipv4;
        logic         is_ipv6;
        logic [31:0]  ipv4;
        logic [127:0] ipv6;
        logic [15:0]  port;
    } hdr_t;

    // Byte 0 of the beat is the first wire byte; multi-byte fields are big-endian.
    function automatic hdr_t parse_hdr(input logic [511:0] d);
        hdr_t        h;
        logic [15:0] etype;
        etype     = {d[8*OFF_ETYPE +: 8], d[8*(OFF_ETYPE+1) +: 8]};
        h.is_ipv4 = (etype == ETYPE_IPV4);
        h.is_ipv6 = (etype == ETYPE_IPV6);
        for (int b = 0; b < 4; b++)
            h.ipv4[31-8*b -: 8] = d[8*(OFF_IPV4_DST+b) +: 8];
        for (int b = 0; b < 16; b++)
            h.ipv6[127-8*b -: 8] = d[8*(OFF_IPV6_DST+b) +: 8];
        h.port = h.is_ipv6 ? {d[8*OFF_IPV6_DPORT +: 8], d[8*(OFF_IPV6_DPORT+1) +: 8]}
                           : {d[8*OFF_IPV4_DPORT +: 8], d[8*(OFF_IPV4_DPORT+1) +: 8]};
        return h;
    endfunction

endpackage

// File: rtl/filter_rule_match.sv
// Combinational compare of one parsed header against one filter rule.
module filter_rule_match
    import filter_pkg::*;
(
    input  hdr_t  i_hdr,
    input  rule_t i_rule,
    output logic  o_match
);

    logic w_addr_eq;
    logic w_port_ok;

    assign w_addr_eq = (i_hdr.is_ipv4 && (i_hdr.ipv4 == i_rule.ipv4)) ||
                       (i_hdr.is_ipv6 && (i_hdr.ipv6 == i_rule.ipv6));
    // A rule port of zero acts as a wildcard.
    assign w_port_ok = (i_rule.port == 16'd0) || (i_rule.port == i_hdr.port);
    assign o_match   = i_rule.en && w_addr_eq && w_port_ok;

endmodule

// File: rtl/filter_rx_multi_rule.sv
// Two-stage AXI4-Stream RX filter: per-packet pass/drop from prioritised rules, with saturating stats.
module filter_rx_multi_rule
    import filter_pkg::*;
#(
    parameter int NUM_RULES    = 4,
    parameter int CNT_WIDTH    = 32,
    parameter bit DEFAULT_PASS = 1'b0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           s_axis_tvalid,
    input  logic [511:0]                   s_axis_tdata,
    input  logic [63:0]                    s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic [47:0]                    s_axis_tuser,
    output logic                           s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [511:0]                   m_axis_tdata,
    output logic [63:0]                    m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [47:0]                    m_axis_tuser,
    input  logic                           m_axis_tready,
    input  logic [NUM_RULES-1:0]           cfg_rule_en,
    input  logic [NUM_RULES*32-1:0]        cfg_rule_ipv4,
    input  logic [NUM_RULES*128-1:0]       cfg_rule_ipv6,
    input  logic [NUM_RULES*16-1:0]        cfg_rule_port,
    input  logic                           cnt_clear,
    output logic [NUM_RULES*CNT_WIDTH-1:0] rule_hit_count,
    output logic [CNT_WIDTH-1:0]           total_packets,
    output logic [CNT_WIDTH-1:0]           dropped_packets
);

    logic                 w_adv, w_acc, w_hit, w_pass, w_cnt_ev;
    logic [WIN_W-1:0]     w_win;
    logic [NUM_RULES-1:0] w_match;
    hdr_t                 w_hdr;

    logic                 r_expect_sop, r_pkt_pass;
    logic                 r_vld_p1, r_sop_p1, r_pass_p1, r_hit_p1;
    logic [WIN_W-1:0]     r_win_p1;
    logic [511:0]         r_tdata_p1;
    logic [63:0]          r_tkeep_p1;
    logic                 r_tlast_p1;
    logic [47:0]          r_tuser_p1;
    logic                 r_vld_p2;
    logic [511:0]         r_tdata_p2;
    logic [63:0]          r_tkeep_p2;
    logic                 r_tlast_p2;
    logic [47:0]          r_tuser_p2;
    logic [CNT_WIDTH-1:0] r_hit_cnt [NUM_RULES];
    logic [CNT_WIDTH-1:0] r_total, r_dropped;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign w_adv         = m_axis_tready | ~r_vld_p2;
    assign s_axis_tready = w_adv & ~areset;
    assign w_acc         = s_axis_tvalid & s_axis_tready;
    assign w_hdr         = parse_hdr(s_axis_tdata);

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
        rule_t w_rule;
        assign w_rule = {cfg_rule_en[g], cfg_rule_ipv4[32*g +: 32],
                         cfg_rule_ipv6[128*g +: 128], cfg_rule_port[16*g +: 16]};
        filter_rule_match u_match (
            .i_hdr   (w_hdr),
            .i_rule  (w_rule),
            .o_match (w_match[g])
        );
        assign rule_hit_count[CNT_WIDTH*g +: CNT_WIDTH] = r_hit_cnt[g];
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_win = WIN_W'(i);
            end
        end
    end
    assign w_pass = w_hit | DEFAULT_PASS;

    // p1: match stage; the SOP decision is latched and reused for the rest of the packet
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vld_p1     <= 1'b0;
            r_expect_sop <= 1'b1;
            r_pkt_pass   <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1   <= w_acc;
            r_sop_p1   <= w_acc & r_expect_sop;
            r_pass_p1  <= r_expect_sop ? w_pass : r_pkt_pass;
            r_hit_p1   <= w_hit;
            r_win_p1   <= w_win;
            r_tdata_p1 <= s_axis_tdata;
            r_tkeep_p1 <= s_axis_tkeep;
            r_tlast_p1 <= s_axis_tlast;
            r_tuser_p1 <= s_axis_tuser;
            if (w_acc) begin
                r_expect_sop <= s_axis_tlast;
                if (r_expect_sop)
                    r_pkt_pass <= w_pass;
            end
        end
    end

    // p2: output stage; dropped beats advance as bubbles
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vld_p2   <= 1'b0;
            r_tdata_p2 <= '0;
            r_tkeep_p2 <= '0;
            r_tlast_p2 <= 1'b0;
            r_tuser_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p2   <= r_vld_p1 & r_pass_p1;
            r_tdata_p2 <= r_tdata_p1;
            r_tkeep_p2 <= r_tkeep_p1;
            r_tlast_p2 <= r_tlast_p1;
            r_tuser_p2 <= r_tuser_p1;
        end
    end

    assign w_cnt_ev = w_adv & r_vld_p1 & r_sop_p1;

    always_ff @(posedge aclk) begin
        if (areset || cnt_clear) begin
            r_total   <= '0;
            r_dropped <= '0;
            for (int i = 0; i < NUM_RULES; i++)
                r_hit_cnt[i] <= '0;
        end else if (w_cnt_ev) begin
            r_total <= sat_inc(r_total);
            if (!r_pass_p1)
                r_dropped <= sat_inc(r_dropped);
            for (int i = 0; i < NUM_RULES; i++)
                if (r_hit_p1 && (r_win_p1 == WIN_W'(i)))
                    r_hit_cnt[i] <= sat_inc(r_hit_cnt[i]);
        end
    end

    assign m_axis_tvalid   = r_vld_p2;
    assign m_axis_tdata    = r_tdata_p2;
    assign m_axis_tkeep    = r_tkeep_p2;
    assign m_axis_tlast    = r_tlast_p2;
    assign m_axis_tuser    = r_tuser_p2;
    assign total_packets   = r_total;
    assign dropped_packets = r_dropped;

endmodule

// File: tb/tb_filter_rx_multi_rule.sv
// Self-checking bench for filter_rx_multi_rule against a packet-level reference model.
module tb_filter_rx_multi_rule;

    localparam int NR  = 4;
    localparam int CW  = 32;
    localparam int CWS = 4;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [47:0]  user;
    } beat_t;

    typedef struct {
        logic [15:0]  et;
        logic [31:0]  ip4;
        logic [127:0] ip6;
        logic [15:0]  port;
        int           nb;
    } pkt_t;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              s_tvalid, s_tlast, s_tready;
    logic [511:0]      s_tdata;
    logic [63:0]       s_tkeep;
    logic [47:0]       s_tuser;
    logic              m_tvalid, m_tlast, m_tready;
    logic [511:0]      m_tdata;
    logic [63:0]       m_tkeep;
    logic [47:0]       m_tuser;
    logic [NR-1:0]     cfg_en;
    logic [NR*32-1:0]  cfg_ip4;
    logic [NR*128-1:0] cfg_ip6;
    logic [NR*16-1:0]  cfg_port;
    logic              cnt_clear;
    logic [NR*CW-1:0]  hit;
    logic [CW-1:0]     total, dropped;

    logic              s_tready_s, sm_tvalid, sm_tlast;
    logic [511:0]      sm_tdata;
    logic [63:0]       sm_tkeep;
    logic [47:0]       sm_tuser;
    logic [NR*CWS-1:0] hit_s;
    logic [CWS-1:0]    total_s, dropped_s;

    int    checks = 0, errors = 0, cyc = 0, stab_viol = 0, stall_seen = 0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$], got_q[$];
    int    got_cyc[$], acc_q[$];
    int    exp_total = 0, exp_drop = 0;
    int    exp_hit[NR];

    bit           m_en[NR];
    logic [31:0]  m_ip4[NR];
    logic [127:0] m_ip6[NR];
    logic [15:0]  m_port[NR];

    localparam logic [127:0] V6_A = 128'h2001_0db8_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] V6_B = 128'hfe80_0000_0000_0000_0000_0000_0000_0005;

    filter_rx_multi_rule #(.NUM_RULES(NR), .CNT_WIDTH(CW), .DEFAULT_PASS(1'b0)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .cfg_rule_en(cfg_en), .cfg_rule_ipv4(cfg_ip4), .cfg_rule_ipv6(cfg_ip6),
        .cfg_rule_port(cfg_port), .cnt_clear(cnt_clear),
        .rule_hit_count(hit), .total_packets(total), .dropped_packets(dropped)
    );

    filter_rx_multi_rule #(.NUM_RULES(NR), .CNT_WIDTH(CWS), .DEFAULT_PASS(1'b0)) dut_s (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_s),
        .m_axis_tvalid(sm_tvalid), .m_axis_tdata(sm_tdata), .m_axis_tkeep(sm_tkeep),
        .m_axis_tlast(sm_tlast), .m_axis_tuser(sm_tuser), .m_axis_tready(m_tready),
        .cfg_rule_en(cfg_en), .cfg_rule_ipv4(cfg_ip4), .cfg_rule_ipv6(cfg_ip6),
        .cfg_rule_port(cfg_port), .cnt_clear(cnt_clear),
        .rule_hit_count(hit_s), .total_packets(total_s), .dropped_packets(dropped_s)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;
    always @(posedge aclk) begin
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    end

    beat_t prev_b;
    bit    prev_stall = 1'b0;
    always @(negedge aclk) begin
        beat_t cur;
        cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
        if (prev_stall && (!m_tvalid || cur != prev_b)) stab_viol++;
        prev_stall = m_tvalid && !m_tready;
        prev_b     = cur;
        if (m_tvalid && m_tready) begin
            got_q.push_back(cur);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Reference decision: index of the winning rule, or -1 when the packet gets the default action.
    function automatic int model_win(input pkt_t p);
        for (int r = 0; r < NR; r++) begin
            if (m_en[r] && (m_port[r] == 16'd0 || m_port[r] == p.port)) begin
                if (p.et == 16'h0800 && m_ip4[r] == p.ip4) return r;
                if (p.et == 16'h86DD && m_ip6[r] == p.ip6) return r;
            end
        end
        return -1;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [511:0] mk_sop(input pkt_t p);
        logic [511:0] d;
        d = rand512();
        d[8*12 +: 8] = p.et[15:8];
        d[8*13 +: 8] = p.et[7:0];
        if (p.et == 16'h0800) begin
            for (int i = 0; i < 4; i++) d[8*(30+i) +: 8] = p.ip4[31-8*i -: 8];
            d[8*36 +: 8] = p.port[15:8];
            d[8*37 +: 8] = p.port[7:0];
        end else if (p.et == 16'h86DD) begin
            for (int i = 0; i < 16; i++) d[8*(38+i) +: 8] = p.ip6[127-8*i -: 8];
            d[8*56 +: 8] = p.port[15:8];
            d[8*57 +: 8] = p.port[7:0];
        end
        return d;
    endfunction

    task automatic apply_cfg();
        for (int r = 0; r < NR; r++) begin
            cfg_en[r]              = m_en[r];
            cfg_ip4[32*r +: 32]    = m_ip4[r];
            cfg_ip6[128*r +: 128]  = m_ip6[r];
            cfg_port[16*r +: 16]   = m_port[r];
        end
    endtask

    task automatic clear_cnt();
        @(posedge aclk); #1;
        cnt_clear = 1'b1;
        @(posedge aclk); #1;
        cnt_clear = 1'b0;
        exp_total = 0;
        exp_drop  = 0;
        for (int r = 0; r < NR; r++) exp_hit[r] = 0;
    endtask

    task automatic flush_q();
        exp_q.delete(); got_q.delete(); got_cyc.delete(); acc_q.delete();
    endtask

    task automatic send_beat(input beat_t b);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tlast  = b.last;
        s_tuser  = b.user;
        while (!acc) begin
            @(negedge aclk);
            if (s_tready) begin
                acc = 1'b1;
                acc_q.push_back(cyc);
            end else begin
                stall_seen++;
            end
            @(posedge aclk); #1;
            guard++;
            if (guard > 500) begin
                $display("FAIL send_beat: s_axis_tready stuck low, got %0b want 1", s_tready);
                $fatal(1);
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input pkt_t p, input int gap_max);
        int    w;
        beat_t b;
        w = model_win(p);
        exp_total++;
        if (w < 0) exp_drop++;
        else       exp_hit[w]++;
        for (int i = 0; i < p.nb; i++) begin
            b.data = (i == 0) ? mk_sop(p) : rand512();
            b.last = (i == p.nb - 1);
            b.keep = b.last ? {$urandom, $urandom} | 64'h1 : '1;
            b.user = {16'($urandom), 32'($urandom)};
            if (w >= 0) exp_q.push_back(b);
            send_beat(b);
            repeat ($urandom_range(0, gap_max)) begin @(posedge aclk); #1; end
        end
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 600) begin
            @(posedge aclk); #1;
            n++;
        end
        repeat (8) begin @(posedge aclk); #1; end
        ok = (got_q.size() >= exp_q.size());
    endtask

    task automatic test_reset();
        repeat (3) begin @(posedge aclk); #1; end
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: s_tready=%b m_tvalid=%b want 0/0", s_tready, m_tvalid);
        end
        checks++;
        if (m_tdata !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: m_tdata nonzero=%b want 0", |m_tdata);
        end
        checks++;
        if (total !== '0 || dropped !== '0 || hit !== '0) begin
            errors++;
            $display("FAIL reset_cnt: total=%0d dropped=%0d hit=%h want 0", total, dropped, hit);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: s_tready=%b m_tvalid=%b want 1/0", s_tready, m_tvalid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_ipv4_basic();
        pkt_t p;
        bit   ok;
        for (int r = 0; r < NR; r++) begin
            m_en[r] = 1'b0; m_ip4[r] = 32'($urandom); m_ip6[r] = {4{$urandom}}; m_port[r] = 16'd0;
        end
        m_en[0] = 1'b1; m_ip4[0] = 32'h0A00_0001;
        apply_cfg();
        clear_cnt();
        flush_q();
        p = '{et: 16'h0800, ip4: 32'h0A00_0001, ip6: '0, port: 16'd1234, nb: 3};
        send_pkt(p, 0);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 3) begin
            errors++;
            $display("FAIL v4_count: beats out=%0d want 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] - acc_q[i] != 2) begin
                errors++;
                $display("FAIL v4_beat%0d: latency=%0d want 2, data_eq=%0b", i, got_cyc[i] - acc_q[i], got_q[i] === exp_q[i]);
            end
        end
        checks++;
        if (hit[0 +: CW] !== 1 || total !== 1 || dropped !== 0) begin
            errors++;
            $display("FAIL v4_cnt: hit0=%0d total=%0d dropped=%0d want 1/1/0", hit[0 +: CW], total, dropped);
        end
    endtask

    task automatic test_ipv6_priority();
        pkt_t p;
        bit   ok;
        m_en[1] = 1'b1; m_ip6[1] = V6_A; m_port[1] = 16'd80;
        m_en[2] = 1'b1; m_ip6[2] = V6_A; m_port[2] = 16'd80;
        apply_cfg();
        clear_cnt();
        flush_q();
        p = '{et: 16'h86DD, ip4: '0, ip6: V6_A, port: 16'd80, nb: 1};
        send_pkt(p, 0);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL v6_pass: beats out=%0d want 1", got_q.size());
        end
        checks++;
        if (hit[CW +: CW] !== 1 || hit[2*CW +: CW] !== 0 || hit[0 +: CW] !== 0) begin
            errors++;
            $display("FAIL v6_prio: hit1=%0d hit2=%0d hit0=%0d want 1/0/0", hit[CW +: CW], hit[2*CW +: CW], hit[0 +: CW]);
        end
    endtask

    task automatic test_arp_drop();
        pkt_t p;
        bit   ok;
        int   st0;
        clear_cnt();
        flush_q();
        st0 = stall_seen;
        p = '{et: 16'h0806, ip4: 32'h0A00_0001, ip6: V6_A, port: 16'd80, nb: 2};
        send_pkt(p, 0);
        drain(ok);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL arp_out: beats out=%0d want 0", got_q.size());
        end
        checks++;
        if (stall_seen != st0) begin
            errors++;
            $display("FAIL arp_ready: stalled cycles=%0d want 0", stall_seen - st0);
        end
        checks++;
        if (dropped !== 1 || total !== 1) begin
            errors++;
            $display("FAIL arp_cnt: dropped=%0d total=%0d want 1/1", dropped, total);
        end
    endtask

    task automatic test_random_backpressure();
        pkt_t p;
        bit   ok;
        int   k;
        logic [15:0] ports[4];
        logic [15:0] nonip[3];
        ports[0] = 16'd80; ports[1] = 16'd443; ports[2] = 16'd53; ports[3] = 16'd0;
        nonip[0] = 16'h0806; nonip[1] = 16'h8100; nonip[2] = 16'h88CC;
        m_en[0] = 1'b1; m_ip4[0] = 32'h0A00_0001; m_ip6[0] = {4{$urandom}}; m_port[0] = 16'd0;
        m_en[1] = 1'b1; m_ip4[1] = 32'hC0A8_0107; m_ip6[1] = V6_A;           m_port[1] = 16'd80;
        m_en[2] = 1'b1; m_ip4[2] = 32'h0A00_0001; m_ip6[2] = V6_A;           m_port[2] = 16'd443;
        m_en[3] = 1'b0; m_ip4[3] = 32'hAC10_0009; m_ip6[3] = V6_B;           m_port[3] = 16'd0;
        apply_cfg();
        clear_cnt();
        flush_q();
        stab_viol = 0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 100; n++) begin
            k = $urandom_range(0, 9);
            p.et   = (k < 4) ? 16'h0800 : (k < 8) ? 16'h86DD : nonip[$urandom_range(0, 2)];
            p.ip4  = ($urandom_range(0, 2) == 0) ? 32'($urandom) : m_ip4[$urandom_range(0, NR-1)];
            p.ip6  = ($urandom_range(0, 2) == 0) ? {4{$urandom}} : m_ip6[$urandom_range(0, NR-1)];
            p.port = ports[$urandom_range(0, 3)];
            if (p.port == 16'd0) p.port = 16'($urandom);
            p.nb   = $urandom_range(1, 4);
            send_pkt(p, 2);
        end
        drain(ok);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count: beats out=%0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_beat%0d: got user=%h last=%b want user=%h last=%b", i, got_q[i].user, got_q[i].last, exp_q[i].user, exp_q[i].last);
            end
        end
        checks++;
        if (total !== CW'(exp_total) || dropped !== CW'(exp_drop)) begin
            errors++;
            $display("FAIL rnd_pkts: total=%0d dropped=%0d want %0d/%0d", total, dropped, exp_total, exp_drop);
        end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (hit[CW*r +: CW] !== CW'(exp_hit[r])) begin
                errors++;
                $display("FAIL rnd_hit%0d: got %0d want %0d", r, hit[CW*r +: CW], exp_hit[r]);
            end
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL rnd_stable: stall violations=%0d want 0", stab_viol);
        end
    endtask

    task automatic test_saturation();
        pkt_t  p;
        bit    ok;
        beat_t b;
        clear_cnt();
        flush_q();
        p = '{et: 16'h0800, ip4: 32'h0A00_0001, ip6: '0, port: 16'd7, nb: 1};
        for (int n = 0; n < 20; n++) send_pkt(p, 0);
        drain(ok);
        checks++;
        if (total_s !== 4'd15 || hit_s[0 +: CWS] !== 4'd15 || total !== 20) begin
            errors++;
            $display("FAIL sat: total_s=%0d hit0_s=%0d total=%0d want 15/15/20", total_s, hit_s[0 +: CWS], total);
        end
        b = '{data: mk_sop(p), keep: '1, last: 1'b1, user: 48'h1};
        s_tvalid = 1'b1; s_tdata = b.data; s_tkeep = b.keep; s_tlast = 1'b1; s_tuser = b.user;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        cnt_clear = 1'b1;
        @(posedge aclk); #1;
        cnt_clear = 1'b0;
        @(negedge aclk);
        checks++;
        if (total_s !== '0 || hit_s !== '0 || total !== '0 || hit !== '0) begin
            errors++;
            $display("FAIL clear_wins: total_s=%0d total=%0d hit0=%0d want 0/0/0", total_s, total, hit[0 +: CW]);
        end
        @(posedge aclk); #1;
        repeat (4) begin @(posedge aclk); #1; end
        exp_total = 0;
        exp_drop  = 0;
        for (int r = 0; r < NR; r++) exp_hit[r] = 0;
        flush_q();
    endtask

    task automatic test_reset_midpacket();
        pkt_t  p;
        bit    ok;
        beat_t b;
        flush_q();
        p = '{et: 16'h0800, ip4: 32'h0A00_0001, ip6: '0, port: 16'd9, nb: 4};
        for (int i = 0; i < 2; i++) begin
            b = '{data: (i == 0) ? mk_sop(p) : rand512(), keep: '1, last: 1'b0, user: 48'(i)};
            send_beat(b);
        end
        s_tvalid = 1'b1; s_tdata = rand512(); s_tlast = 1'b0;
        areset = 1'b1;
        @(posedge aclk); #1;
        got_q.delete();
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== '0) begin
            errors++;
            $display("FAIL midrst_state: s_tready=%b m_tvalid=%b want 0/0", s_tready, m_tvalid);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        s_tvalid = 1'b0;
        repeat (10) begin @(posedge aclk); #1; end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_out: beats after reset=%0d want 0", got_q.size());
        end
        flush_q();
        exp_total = 0;
        exp_drop  = 0;
        for (int r = 0; r < NR; r++) exp_hit[r] = 0;
        p = '{et: 16'h0800, ip4: 32'h0B0B_0B0B, ip6: '0, port: 16'd9, nb: 2};
        send_pkt(p, 0);
        p = '{et: 16'h0800, ip4: 32'h0A00_0001, ip6: '0, port: 16'd9, nb: 2};
        send_pkt(p, 0);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL midrst_next: beats out=%0d want 2", got_q.size());
        end
        checks++;
        if (total !== 2 || dropped !== 1 || hit[0 +: CW] !== 1) begin
            errors++;
            $display("FAIL midrst_cnt: total=%0d dropped=%0d hit0=%0d want 2/1/1", total, dropped, hit[0 +: CW]);
        end
    endtask

    initial begin
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        m_tready = 1'b1; cnt_clear = 1'b0;
        cfg_en = '0; cfg_ip4 = '0; cfg_ip6 = '0; cfg_port = '0;
        for (int r = 0; r < NR; r++) exp_hit[r] = 0;
        test_reset();
        test_ipv4_basic();
        test_ipv6_priority();
        test_arp_drop();
        test_random_backpressure();
        test_saturation();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
